decode_stage: RTL and testbench

- Registered, parametrised instruction-decode pipeline stage sitting between fetch (instruction register) and register-file/ALU issue.
- Splits the instruction word into register addresses, immediates, ALU op and opcode, using the existing field layout and address-selection rules.
- Adds a valid/ready handshake on both sides, a register scoreboard that stalls on RAW hazards, writeback release, and flush.

---
 rtl/decode_stage_pkg.sv | 17 +
 rtl/decode_stage_ir_fields_decode.sv | 78 +++++++
 rtl/decode_stage.sv | 97 +++++++++
 tb/tb_decode_stage.sv | 506 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_stage_pkg.sv
// Shared widths and opcode encodings for the decode stage.
package decode_stage_pkg;

  localparam int DEF_WORD_SIZE     = 16;
  localparam int DEF_REG_ADDR_SIZE = 3;
  localparam int DEF_ALU_OP_SIZE   = 3;
  localparam int OPC_SIZE          = 5;

  localparam logic [OPC_SIZE-1:0] OP_LOAD_R  = 5'b10000;
  localparam logic [OPC_SIZE-1:0] OP_STORE_R = 5'b10001;
  localparam logic [OPC_SIZE-1:0] OP_STORE   = 5'b10010;
  localparam logic [OPC_SIZE-1:0] OP_BR      = 5'b11000;
  localparam logic [OPC_SIZE-1:0] OP_BL      = 5'b11001;
  localparam logic [OPC_SIZE-1:0] OP_CMP     = 5'b01110;
  localparam logic [OPC_SIZE-1:0] OP_CMPI    = 5'b01111;

endpackage

// File: rtl/decode_stage_ir_fields_decode.sv
// Combinational split of an instruction word into
// register addresses, immediates and ALU op.
module ir_fields_decode
  import decode_stage_pkg::*;
#(
  parameter int WORD_SIZE     = DEF_WORD_SIZE,
  parameter int REG_ADDR_SIZE = DEF_REG_ADDR_SIZE,
  parameter int ALU_OP_SIZE   = DEF_ALU_OP_SIZE,
  parameter logic [REG_ADDR_SIZE-1:0] LR_ADDR = '1
) (
  input  logic [WORD_SIZE-1:0]     i_word,
  output logic [REG_ADDR_SIZE-1:0] o_reg_addr1,
  output logic [REG_ADDR_SIZE-1:0] o_reg_addr2,
  output logic [REG_ADDR_SIZE-1:0] o_reg_addr_in,
  output logic                     o_wr_en,
  output logic [10:0]              o_imm1,
  output logic [7:0]               o_imm2,
  output logic [4:0]               o_imm3,
  output logic [ALU_OP_SIZE-1:0]   o_alu_op,
  output logic [OPC_SIZE-1:0]      o_opcode
);

  localparam int R = REG_ADDR_SIZE;

  logic [R-1:0]        w_ra;
  logic [R-1:0]        w_rb;
  logic [R-1:0]        w_rc;
  logic [OPC_SIZE-1:0] w_op;
  logic w_is_ld_r;
  logic w_is_st_r;
  logic w_is_st;
  logic w_is_br;
  logic w_is_bl;
  logic w_is_cmp;
  logic w_is_cmpi;

  assign w_ra = i_word[R-1:0];
  assign w_rb = i_word[2*R-1:R];
  assign w_rc = i_word[3*R-1:2*R];
  assign w_op = i_word[WORD_SIZE-1:WORD_SIZE-OPC_SIZE];

  assign w_is_ld_r = (w_op == OP_LOAD_R);
  assign w_is_st_r = (w_op == OP_STORE_R);
  assign w_is_st   = (w_op == OP_STORE);
  assign w_is_br   = (w_op == OP_BR);
  assign w_is_bl   = (w_op == OP_BL);
  assign w_is_cmp  = (w_op == OP_CMP);
  assign w_is_cmpi = (w_op == OP_CMPI);

  assign o_opcode = w_op;
  assign o_imm1   = i_word[10:0];
  assign o_imm2   = i_word[10:3];
  assign o_imm3   = i_word[10:6];

  always_comb begin
    o_reg_addr1 = w_rb;
    if (w_is_br | w_is_st | w_is_cmp | w_is_cmpi)
      o_reg_addr1 = w_ra;
  end

  always_comb begin
    o_reg_addr2 = w_rc;
    unique case (1'b1)
      w_is_st_r: o_reg_addr2 = w_ra;
      w_is_cmp:  o_reg_addr2 = w_rb;
      default:   o_reg_addr2 = w_rc;
    endcase
  end

  assign o_reg_addr_in = w_is_bl ? LR_ADDR : w_ra;

  assign o_alu_op = (w_is_ld_r | w_is_st_r) ?
    '0 : w_op[ALU_OP_SIZE-1:0];

  assign o_wr_en = ~(w_is_st | w_is_st_r | w_is_br
                   | w_is_cmp | w_is_cmpi);

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: holding register, valid/ready
// handshake and a per-register RAW scoreboard.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int WORD_SIZE     = DEF_WORD_SIZE,
  parameter int REG_ADDR_SIZE = DEF_REG_ADDR_SIZE,
  parameter int ALU_OP_SIZE   = DEF_ALU_OP_SIZE,
  parameter int NREGS         = 2**REG_ADDR_SIZE,
  parameter logic [REG_ADDR_SIZE-1:0] LR_ADDR =
    REG_ADDR_SIZE'(NREGS-1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WORD_SIZE-1:0]     instr,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [REG_ADDR_SIZE-1:0] reg_addr1,
  output logic [REG_ADDR_SIZE-1:0] reg_addr2,
  output logic [REG_ADDR_SIZE-1:0] reg_addr_in,
  output logic                     wr_en,
  output logic [10:0]              imm1,
  output logic [7:0]               imm2,
  output logic [4:0]               imm3,
  output logic [ALU_OP_SIZE-1:0]   alu_op,
  output logic [4:0]               opcode,
  input  logic                     wb_valid,
  input  logic [REG_ADDR_SIZE-1:0] wb_addr,
  output logic [NREGS-1:0]         busy
);

  logic                 r_hold_valid;
  logic [WORD_SIZE-1:0] r_word;
  logic [NREGS-1:0]     r_busy;

  logic [NREGS-1:0] w_clr;
  logic [NREGS-1:0] w_set;
  logic [NREGS-1:0] w_busy_eff;
  logic             w_hazard;
  logic             w_issue;
  logic             w_accept;

  ir_fields_decode #(
    .WORD_SIZE     (WORD_SIZE),
    .REG_ADDR_SIZE (REG_ADDR_SIZE),
    .ALU_OP_SIZE   (ALU_OP_SIZE),
    .LR_ADDR       (LR_ADDR)
  ) u_fields (
    .i_word        (r_word),
    .o_reg_addr1   (reg_addr1),
    .o_reg_addr2   (reg_addr2),
    .o_reg_addr_in (reg_addr_in),
    .o_wr_en       (wr_en),
    .o_imm1        (imm1),
    .o_imm2        (imm2),
    .o_imm3        (imm3),
    .o_alu_op      (alu_op),
    .o_opcode      (opcode)
  );

  // A writeback landing this cycle already frees its register.
  assign w_clr = wb_valid ? (NREGS'(1) << wb_addr) : '0;
  assign w_busy_eff = r_busy & ~w_clr;
  assign w_hazard = w_busy_eff[reg_addr1]
                  | w_busy_eff[reg_addr2];

  assign out_valid = r_hold_valid & ~w_hazard & ~flush;
  assign w_issue   = out_valid & out_ready;
  assign in_ready  = ~r_hold_valid | w_issue | flush;
  assign w_accept  = in_valid & in_ready;

  assign w_set = (w_issue & wr_en) ?
    (NREGS'(1) << reg_addr_in) : '0;

  assign busy = r_busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hold_valid <= 1'b0;
      r_word       <= '0;
      r_busy       <= '0;
    end else begin
      if (w_accept) begin
        r_hold_valid <= 1'b1;
        r_word       <= instr;
      end else if (w_issue | flush) begin
        r_hold_valid <= 1'b0;
      end
      // Set after clear: the newer producer owns the register.
      r_busy <= (r_busy & ~w_clr) | w_set;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Scenario bench for decode_stage with an issue-order
// scoreboard of expected decode results.
module tb_decode_stage;
  import decode_stage_pkg::*;

  typedef struct packed {
    logic [2:0]  a1;
    logic [2:0]  a2;
    logic [2:0]  ain;
    logic        we;
    logic [2:0]  alu;
    logic [4:0]  op;
    logic [10:0] imm1;
    logic [7:0]  imm2;
    logic [4:0]  imm3;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] instr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  reg_addr1;
  logic [2:0]  reg_addr2;
  logic [2:0]  reg_addr_in;
  logic        wr_en;
  logic [10:0] imm1;
  logic [7:0]  imm2;
  logic [4:0]  imm3;
  logic [2:0]  alu_op;
  logic [4:0]  opcode;
  logic        wb_valid;
  logic [2:0]  wb_addr;
  logic [7:0]  busy;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t q[$];
  exp_t m_exp;
  exp_t m_act;

  decode_stage dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .instr       (instr),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .reg_addr1   (reg_addr1),
    .reg_addr2   (reg_addr2),
    .reg_addr_in (reg_addr_in),
    .wr_en       (wr_en),
    .imm1        (imm1),
    .imm2        (imm2),
    .imm3        (imm3),
    .alu_op      (alu_op),
    .opcode      (opcode),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mk(
    input logic [4:0] op,
    input logic [2:0] rc,
    input logic [2:0] rb,
    input logic [2:0] ra
  );
    return {op, 2'b10, rc, rb, ra};
  endfunction

  function automatic exp_t model(input logic [15:0] w);
    exp_t e;
    logic [4:0] op;
    op     = w[15:11];
    e.op   = op;
    e.imm1 = w[10:0];
    e.imm2 = w[10:3];
    e.imm3 = w[10:6];
    if (op == OP_BR || op == OP_STORE ||
        op == OP_CMP || op == OP_CMPI)
      e.a1 = w[2:0];
    else
      e.a1 = w[5:3];
    if (op == OP_STORE_R)   e.a2 = w[2:0];
    else if (op == OP_CMP)  e.a2 = w[5:3];
    else                    e.a2 = w[8:6];
    e.ain = (op == OP_BL) ? 3'd7 : w[2:0];
    e.alu = (op == OP_LOAD_R || op == OP_STORE_R) ?
            3'd0 : op[2:0];
    e.we  = !(op == OP_STORE || op == OP_STORE_R ||
              op == OP_BR || op == OP_CMP ||
              op == OP_CMPI);
    return e;
  endfunction

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      n_checks++;
      m_act = {reg_addr1, reg_addr2, reg_addr_in, wr_en,
               alu_op, opcode, imm1, imm2, imm3};
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_issue: got %h, none expected",
                 m_act);
      end else begin
        m_exp = q.pop_front();
        if (m_act !== m_exp) begin
          n_fail++;
          $display("FAIL sb_decode: got %h, expected %h",
                   m_act, m_exp);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    in_valid = 1'b0; instr = '0; flush = 1'b0;
    out_ready = 1'b0; wb_valid = 1'b0; wb_addr = '0;
    #3;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_out_valid: got %b, expected 0", out_valid);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_in_ready: got %b, expected 1", in_ready);
    end
    n_checks++;
    if (busy !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_busy: got %h, expected 00", busy);
    end
    n_checks++;
    if ({opcode, reg_addr1, reg_addr2, reg_addr_in, wr_en,
         alu_op, imm1} !== {5'd0, 3'd0, 3'd0, 3'd0, 1'b1,
                            3'd0, 11'd0}) begin
      n_fail++;
      $display("FAIL rst_fields: op %h a1 %h a2 %h ain %h we %b",
               opcode, reg_addr1, reg_addr2, reg_addr_in, wr_en);
    end
    tick();
    reset = 1'b0;
    #2;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL post_rst: out_valid %b in_ready %b, need 0/1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_basic;
    logic [15:0] w;
    tick();
    w = mk(5'b00001, 3'd3, 3'd2, 3'd1);
    in_valid = 1'b1; instr = w; out_ready = 1'b1;
    q.push_back(model(w));
    #2;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_accept: in_ready %b out_valid %b, need 1/0",
               in_ready, out_valid);
    end
    tick();
    in_valid = 1'b0;
    #2;
    n_checks++;
    if (out_valid !== 1'b1 || reg_addr1 !== 3'd2 ||
        reg_addr2 !== 3'd3 || reg_addr_in !== 3'd1 ||
        wr_en !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_decode: v %b a1 %0d a2 %0d ain %0d we %b",
               out_valid, reg_addr1, reg_addr2, reg_addr_in, wr_en);
    end
    n_checks++;
    if (imm2 !== w[10:3] || imm3 !== w[10:6]) begin
      n_fail++;
      $display("FAIL basic_imm: imm2 %h imm3 %h, expected %h %h",
               imm2, imm3, w[10:3], w[10:6]);
    end
    tick();
    #2;
    n_checks++;
    if (busy !== 8'b0000_0010 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_busy: busy %b v %b, expected 00000010/0",
               busy, out_valid);
    end
    wb_valid = 1'b1; wb_addr = 3'd1;
    tick();
    wb_valid = 1'b0;
    #2;
    n_checks++;
    if (busy !== 8'h00) begin
      n_fail++;
      $display("FAIL basic_wb: busy %h, expected 00", busy);
    end
  endtask

  task automatic test_hazard_bl;
    logic [15:0] w1;
    logic [15:0] w2;
    tick();
    w1 = mk(OP_BL, 3'd0, 3'd0, 3'd0);
    in_valid = 1'b1; instr = w1;
    q.push_back(model(w1));
    tick();
    w2 = mk(5'b00001, 3'd0, 3'd7, 3'd4);
    instr = w2;
    q.push_back(model(w2));
    #2;
    n_checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b1 ||
        reg_addr_in !== 3'd7) begin
      n_fail++;
      $display("FAIL bl_issue: v %b rdy %b ain %0d, need 1/1/7",
               out_valid, in_ready, reg_addr_in);
    end
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #2;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0 ||
          busy !== 8'h80) begin
        n_fail++;
        $display("FAIL raw_stall: v %b rdy %b busy %h, need 0/0/80",
                 out_valid, in_ready, busy);
      end
      if (i == 0) tick();
    end
    wb_valid = 1'b1; wb_addr = 3'd7;
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL raw_bypass: v %b rdy %b, need 1/1",
               out_valid, in_ready);
    end
    tick();
    wb_valid = 1'b0;
    #2;
    n_checks++;
    if (busy !== 8'h10) begin
      n_fail++;
      $display("FAIL raw_after: busy %h, expected 10", busy);
    end
    wb_valid = 1'b1; wb_addr = 3'd4;
    tick();
    wb_valid = 1'b0;
  endtask

  task automatic test_cmp;
    logic [15:0] w;
    tick();
    w = mk(OP_CMP, 3'd1, 3'd5, 3'd4);
    in_valid = 1'b1; instr = w;
    q.push_back(model(w));
    tick();
    in_valid = 1'b0;
    #2;
    n_checks++;
    if (out_valid !== 1'b1 || reg_addr1 !== 3'd4 ||
        reg_addr2 !== 3'd5 || wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL cmp_decode: v %b a1 %0d a2 %0d we %b",
               out_valid, reg_addr1, reg_addr2, wr_en);
    end
    tick();
    #2;
    n_checks++;
    if (busy !== 8'h00) begin
      n_fail++;
      $display("FAIL cmp_busy: busy %h, expected 00", busy);
    end
  endtask

  task automatic test_backpressure;
    logic [15:0] wa;
    logic [15:0] wb;
    tick();
    out_ready = 1'b0;
    wa = mk(5'b00001, 3'd0, 3'd1, 3'd2);
    in_valid = 1'b1; instr = wa;
    q.push_back(model(wa));
    tick();
    wb = mk(5'b00011, 3'd0, 3'd0, 3'd5);
    instr = wb;
    for (int i = 0; i < 3; i++) begin
      #2;
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          reg_addr_in !== 3'd2 || reg_addr1 !== 3'd1) begin
        n_fail++;
        $display("FAIL bp_hold%0d: v %b rdy %b ain %0d a1 %0d",
                 i, out_valid, in_ready, reg_addr_in, reg_addr1);
      end
      tick();
    end
    out_ready = 1'b1;
    q.push_back(model(wb));
    #2;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: rdy %b v %b, need 1/1",
               in_ready, out_valid);
    end
    tick();
    in_valid = 1'b0;
    #2;
    n_checks++;
    if (out_valid !== 1'b1 || reg_addr_in !== 3'd5) begin
      n_fail++;
      $display("FAIL bp_next: v %b ain %0d, need 1/5",
               out_valid, reg_addr_in);
    end
    tick();
    #2;
    n_checks++;
    if (busy !== 8'h24) begin
      n_fail++;
      $display("FAIL bp_busy: busy %h, expected 24", busy);
    end
    wb_valid = 1'b1; wb_addr = 3'd6;
    tick();
    #2;
    n_checks++;
    if (busy !== 8'h24) begin
      n_fail++;
      $display("FAIL wb_idle_reg: busy %h, expected 24", busy);
    end
    wb_addr = 3'd2;
    tick();
    wb_addr = 3'd5;
    tick();
    wb_valid = 1'b0;
    #2;
    n_checks++;
    if (busy !== 8'h00) begin
      n_fail++;
      $display("FAIL bp_clear: busy %h, expected 00", busy);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] wx;
    logic [15:0] wy;
    tick();
    wx = mk(5'b00001, 3'd0, 3'd0, 3'd3);
    in_valid = 1'b1; instr = wx;
    q.push_back(model(wx));
    tick();
    wy = mk(5'b00010, 3'd0, 3'd0, 3'd3);
    instr = wy;
    q.push_back(model(wy));
    #2;
    n_checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_rate: v %b rdy %b, need 1/1",
               out_valid, in_ready);
    end
    tick();
    in_valid = 1'b0;
    wb_valid = 1'b1; wb_addr = 3'd3;
    #2;
    n_checks++;
    if (out_valid !== 1'b1 || opcode !== 5'b00010) begin
      n_fail++;
      $display("FAIL b2b_second: v %b op %b, need 1/00010",
               out_valid, opcode);
    end
    tick();
    wb_valid = 1'b0;
    #2;
    n_checks++;
    if (busy !== 8'h08) begin
      n_fail++;
      $display("FAIL set_wins: busy %h, expected 08", busy);
    end
    wb_valid = 1'b1; wb_addr = 3'd3;
    tick();
    wb_valid = 1'b0;
  endtask

  task automatic test_flush_reset;
    logic [15:0] wp;
    logic [15:0] wq;
    logic [15:0] wr;
    logic [15:0] ws;
    tick();
    wp = mk(5'b00001, 3'd0, 3'd0, 3'd6);
    in_valid = 1'b1; instr = wp;
    q.push_back(model(wp));
    tick();
    wq = mk(5'b00001, 3'd0, 3'd6, 3'd1);
    instr = wq;
    tick();
    in_valid = 1'b0;
    #2;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 ||
        busy !== 8'h40) begin
      n_fail++;
      $display("FAIL fl_stall: v %b rdy %b busy %h, need 0/0/40",
               out_valid, in_ready, busy);
    end
    tick();
    flush = 1'b1;
    wr = mk(OP_CMP, 3'd0, 3'd3, 3'd2);
    in_valid = 1'b1; instr = wr;
    q.push_back(model(wr));
    #2;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL fl_cycle: v %b rdy %b, need 0/1",
               out_valid, in_ready);
    end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #2;
    n_checks++;
    if (out_valid !== 1'b1 || reg_addr1 !== 3'd2 ||
        busy !== 8'h40) begin
      n_fail++;
      $display("FAIL fl_refill: v %b a1 %0d busy %h, need 1/2/40",
               out_valid, reg_addr1, busy);
    end
    tick();
    ws = mk(5'b00001, 3'd0, 3'd6, 3'd2);
    in_valid = 1'b1; instr = ws;
    #2;
    n_checks++;
    if (busy !== 8'h40) begin
      n_fail++;
      $display("FAIL fl_busy_kept: busy %h, expected 40", busy);
    end
    tick();
    in_valid = 1'b0;
    #2;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rs_stall: v %b rdy %b, need 0/0",
               out_valid, in_ready);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (busy !== 8'h00 || out_valid !== 1'b0 ||
        in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rs_async: busy %h v %b rdy %b, need 00/0/1",
               busy, out_valid, in_ready);
    end
    tick();
    reset = 1'b0;
    #2;
    n_checks++;
    if (busy !== 8'h00 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rs_after: busy %h v %b, need 00/0",
               busy, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hazard_bl();
    test_cmp();
    test_backpressure();
    test_back_to_back();
    test_flush_reset();
    tick();
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
